// File: rtl/i2c_slv_pkg.sv
// Shared definitions for the I2C target register file and its bus front end.
// Contents: the target FSM state enum, the R/W bit encodings and the ACK/NACK
// line levels as seen on SDA during the 9th clock of a byte.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronises SCL/SDA into the clk domain and produces
// single-clk event pulses. Shared between the target and the master.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   scl, sda          raw bus levels (asynchronous to clk)
//   sda_s             synchronised SDA, aligned with the event pulses
//   scl_rise/scl_fall SCL edge pulses
//   start_det         SDA fell while SCL high
//   stop_det          SDA rose while SCL high
// Every pulse appears 3 clk after the pin change that caused it.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Stages 0/1 are the synchroniser, stage 2 is the history for edge detect.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // NOTE: flops are written with <= so every stage samples the pre-edge value
  // of its predecessor; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q     <= '1;
      sda_q     <= '1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda};
      scl_rise  <=  scl_q[1] & ~scl_q[2];
      scl_fall  <= ~scl_q[1] &  scl_q[2];
      start_det <=  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
      stop_det  <=  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];
    end
  end

  assign sda_s = sda_q[2];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a NUM_REGS x 8-bit register file behind a register pointer.
// Write: [addr+W] [ptr] [data]... with auto-increment and wrap.
// Read (only when I2C_SLV_READ_EN is defined): [addr+R] returns regs[ptr],
// master ACK advances the pointer, NACK ends the read. Without the macro a
// read address is NACKed.
// Ports:
//   clk, reset  100 MHz system clock, asynchronous active-high reset
//   SCL, SDA    I2C bus; SDA is only ever pulled low or released
//   regs        flat register file, reg k at [8k+7:8k]
//   wr_strobe   one-clk pulse per committed data byte, wr_index = its register
//   busy        high between a detected START and a detected STOP
module i2c_slave_regfile
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 4,
  localparam int        PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  busy
);

  localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST_REG   = PTR_W'(NUM_REGS - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t           state, state_n;
  logic [7:0]       shift;
  logic [3:0]       bit_cnt;
  logic [PTR_W-1:0] ptr, ptr_inc;
  logic             sda_oe;
  logic             byte_done, addr_ok, ptr_ok;

  assign byte_done = (bit_cnt == 4'd8);
  assign ptr_ok    = (shift < NUM_REGS_B);
  assign ptr_inc   = (ptr == LAST_REG) ? '0 : ptr + PTR_W'(1);

`ifdef I2C_SLV_READ_EN
  logic       rd_mode;
  logic [7:0] tx;
  logic [7:0] rd_cur, rd_next;
  assign addr_ok = (shift[7:1] == DEV_ADDR);
  assign rd_cur  = regs[{ptr, 3'b000} +: 8];
  assign rd_next = regs[{ptr_inc, 3'b000} +: 8];
`else
  assign addr_ok = (shift[7:1] == DEV_ADDR) && (shift[0] == I2C_RW_WRITE);
`endif

  // Released while reset is high so the bus is freed without waiting a clk.
  assign SDA = (sda_oe && !reset) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Byte-level transitions happen on the SCL fall that ends a bit, which is
  // also the only moment the target may change what it drives on SDA.
  always_comb begin
    // NOTE: default first, so paths that leave state_n untouched cannot
    // infer a latch.
    state_n = state;
    if (start_det) begin
      state_n = ADDR;
    end else if (stop_det) begin
      state_n = IDLE;
    end else if (scl_fall) begin
      case (state)
        ADDR:      if (byte_done) state_n = addr_ok ? ADDR_ACK : IGNORE;
`ifdef I2C_SLV_READ_EN
        ADDR_ACK:  state_n = (rd_mode == I2C_RW_READ) ? RDATA : PTR;
        RDATA:     if (byte_done) state_n = RDATA_ACK;
        RDATA_ACK: state_n = (shift[0] == I2C_ACK) ? RDATA : IGNORE;
`else
        ADDR_ACK:  state_n = PTR;
`endif
        PTR:       if (byte_done) state_n = ptr_ok ? PTR_ACK : IGNORE;
        PTR_ACK:   state_n = WDATA;
        WDATA:     if (byte_done) state_n = WDATA_ACK;
        WDATA_ACK: state_n = WDATA;
        default:   state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is reset explicitly; the master may read it
      // back before ever writing it, so it must not power up undefined.
      regs      <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      busy      <= 1'b0;
`ifdef I2C_SLV_READ_EN
      rd_mode   <= I2C_RW_WRITE;
      tx        <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;

      if (start_det)     busy <= 1'b1;
      else if (stop_det) busy <= 1'b0;

      if (start_det || stop_det) begin
        // Any partial byte is dropped; nothing was committed yet.
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {ADDR, PTR, WDATA, RDATA_ACK})
          shift <= {shift[6:0], sda_s};
        if (state inside {ADDR, PTR, WDATA, RDATA})
          bit_cnt <= bit_cnt + 4'd1;
        // Commit on the 8th rise, before the ACK clock.
        if (state == WDATA && bit_cnt == 4'd7) begin
          regs[{ptr, 3'b000} +: 8] <= {shift[6:0], sda_s};
          wr_strobe                <= 1'b1;
          wr_index                 <= ptr;
        end
      end else if (scl_fall) begin
        if (state_n != state) bit_cnt <= '0;

        sda_oe <= 1'b0;
        if (state_n inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) sda_oe <= 1'b1;

        if (state == PTR && state_n == PTR_ACK)     ptr <= shift[PTR_W-1:0];
        if (state == WDATA && state_n == WDATA_ACK) ptr <= ptr_inc;

`ifdef I2C_SLV_READ_EN
        if (state == ADDR && state_n == ADDR_ACK) rd_mode <= shift[0];
        if (state_n == RDATA) begin
          if (state == RDATA) begin
            tx     <= {tx[6:0], 1'b0};
            sda_oe <= ~tx[6];
          end else if (state == ADDR_ACK) begin
            tx     <= rd_cur;
            sda_oe <= ~rd_cur[7];
          end else begin
            // Master ACKed the previous byte: advance and present the next.
            ptr    <= ptr_inc;
            tx     <= rd_next;
            sda_oe <= ~rd_next[7];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile (DEV_ADDR 7'h42, NUM_REGS 4). A
// bit-banged master drives SCL/SDA from negedge clk; expected register
// contents are hand-computed constants. Read expectations follow
// I2C_SLV_READ_EN.
module tb_i2c_slave_regfile;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_drive;
  wire         sda_w;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;

  pullup (sda_w);
  assign sda_w = m_drive ? 1'b0 : 1'bz;

  i2c_slave_regfile #(.DEV_ADDR(7'h42), .NUM_REGS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (sda_w),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int drive_cnt = 0;
  logic [1:0] idx_log [$];

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      idx_log.push_back(wr_index);
    end
    if (!m_drive && sda_w == 1'b0) drive_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_drive = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    m_drive = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    m_drive = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    m_drive = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_drive = ~b; wait_q();
    scl = 1'b1;   wait_q(); wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_drive = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    b = sda_w;      wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mack ? 1'b0 : 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_drive = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (regs !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h want %h", regs, 32'h0); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
    checks++; if (wr_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", wr_index); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_w); end
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    int s0;
    s0 = strobe_cnt;
    idx_log.delete();
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b want 1", busy); end
    write_byte(8'h84, a0);
    write_byte(8'h01, a1);
    write_byte(8'hA5, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL single_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (regs !== 32'h0000A500) begin errors++; $display("FAIL single_regs: got %h want %h", regs, 32'h0000A500); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobe_cnt - s0); end
    checks++; if (idx_log.size() != 1 || idx_log[0] !== 2'd1) begin errors++; $display("FAIL single_index: got %0d entries, first %0d, want 1 entry of 1", idx_log.size(), idx_log.size() > 0 ? idx_log[0] : 2'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b want 0", busy); end
  endtask

  task automatic test_burst_wrap();
    logic a0, a1, a2, a3, a4;
    int s0;
    s0 = strobe_cnt;
    idx_log.delete();
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h02, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    write_byte(8'h33, a4);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin errors++; $display("FAIL burst_acks: got %b want 11111", {a0, a1, a2, a3, a4}); end
    checks++; if (regs !== 32'h2211A533) begin errors++; $display("FAIL burst_regs: got %h want %h", regs, 32'h2211A533); end
    checks++; if (strobe_cnt - s0 !== 3) begin errors++; $display("FAIL burst_strobes: got %0d want 3", strobe_cnt - s0); end
    checks++; if (idx_log.size() != 3 || idx_log[0] !== 2'd2 || idx_log[1] !== 2'd3 || idx_log[2] !== 2'd0) begin
      errors++; $display("FAIL burst_index: got %p want 2 3 0", idx_log);
    end
  endtask

  task automatic test_bad_addr();
    logic a0, a1;
    int s0, d0;
    s0 = strobe_cnt;
    d0 = drive_cnt;
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL badaddr_busy_hi: got %b want 1", busy); end
    write_byte(8'h86, a0);
    write_byte(8'h55, a1);
    i2c_stop();
    checks++; if (a0 !== 1'b0 || a1 !== 1'b0) begin errors++; $display("FAIL badaddr_nack: got acks %b%b want 00", a0, a1); end
    checks++; if (drive_cnt - d0 !== 0) begin errors++; $display("FAIL badaddr_sda_driven: got %0d clk driven want 0", drive_cnt - d0); end
    checks++; if (regs !== 32'h2211A533) begin errors++; $display("FAIL badaddr_regs: got %h want %h", regs, 32'h2211A533); end
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL badaddr_strobes: got %0d want 0", strobe_cnt - s0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badaddr_busy_lo: got %b want 0", busy); end
  endtask

  task automatic test_bad_ptr();
    logic a0, a1, a2;
    int s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h07, a1);
    write_byte(8'h99, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b100) begin errors++; $display("FAIL badptr_acks: got %b want 100", {a0, a1, a2}); end
    checks++; if (regs !== 32'h2211A533) begin errors++; $display("FAIL badptr_regs: got %h want %h", regs, 32'h2211A533); end
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL badptr_strobes: got %0d want 0", strobe_cnt - s0); end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'h85, a2);
`ifdef I2C_SLV_READ_EN
    begin
      logic [7:0] d0, d1;
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      i2c_stop();
      checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
      checks++; if (d0 !== 8'h22) begin errors++; $display("FAIL read_byte0: got %h want 22", d0); end
      checks++; if (d1 !== 8'h33) begin errors++; $display("FAIL read_byte1: got %h want 33", d1); end
    end
`else
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b110) begin errors++; $display("FAIL read_addr_nack: got %b want 110", {a0, a1, a2}); end
`endif
    checks++; if (regs !== 32'h2211A533) begin errors++; $display("FAIL read_regs: got %h want %h", regs, 32'h2211A533); end
  endtask

  task automatic test_partial_and_reset();
    logic a0, a1;
    int s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h00, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL partial_acks: got %b want 11", {a0, a1}); end
    checks++; if (regs !== 32'h2211A533) begin errors++; $display("FAIL partial_regs: got %h want %h", regs, 32'h2211A533); end
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL partial_strobes: got %0d want 0", strobe_cnt - s0); end

    // Reset lands in the middle of the pointer ACK clock.
    i2c_start();
    write_byte(8'h84, a0);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    m_drive = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    checks++; if (sda_w !== 1'b0) begin errors++; $display("FAIL rst_ack_driven: got %b want 0", sda_w); end
    #1 reset = 1'b1;
    #1;
    checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL rst_sda_release: got %b want 1", sda_w); end
    @(negedge clk);
    checks++; if (regs !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_clear: got regs %h busy %b want 0 0", regs, busy); end
    reset = 1'b0;
    wait_q();
    scl = 1'b0; wait_q();
    i2c_stop();
    checks++; if (regs !== 32'h0) begin errors++; $display("FAIL rst_after_regs: got %h want 0", regs); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_bad_addr();
    test_bad_ptr();
    test_read();
    test_partial_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised I2C target (slave) with an N-entry byte register file, register-pointer addressing, auto-increment and optional read-back. It is the next-generation register front end for the video-processing board: an external master writes parameters (position, speed, gravity and future additions), the block presents them as a flat bus to the game/display logic, and it pulses a strobe on every committed byte.

## Interface
- DEV_ADDR, 7'h42, 7-bit I2C device address matched after START.
- NUM_REGS, 4, number of 8-bit registers, 2..16.
- PTR_W, $clog2(NUM_REGS), register pointer width, derived; not overridden.

- clk  in  1  system clock, 100 MHz; SCL ≤ 400 kHz.
- reset  in  1  asynchronous, active-high; clears all state.
- SCL  in  1  I2C clock from master; asynchronous to clk.
- SDA  inout  1  I2C data, open-drain: drive 0 or high-Z, never drive 1.
- regs  out  NUM_REGS*8  flat register file; reg k occupies bits [8k+7:8k].
- wr_strobe  out  1  one-clk pulse when a data byte is committed to regs.
- wr_index  out  PTR_W  index written, valid with wr_strobe.
- busy  out  1  high from detected START to detected STOP.

## Operation
- SCL and SDA pass through 2-FF synchronisers; rise/fall detection uses a third stage.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state; START (including repeated START) → ADDR, STOP → IDLE, both releasing SDA.
- Bits are sampled on SCL rise and MSB first; SDA drive changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits. On a match with R/W=0 → ADDR_ACK (drive 0 for the 9th bit), then PTR. On a match with R/W=1 → ADDR_ACK, then RDATA. On a mismatch → IGNORE (SDA released until the next START or STOP).
- PTR: byte < NUM_REGS → ACK, load the pointer, → WDATA. Otherwise NACK → IGNORE; the pointer is unchanged.
- WDATA: on the 8th bit, write regs[ptr] and pulse wr_strobe/wr_index, then ACK and increment ptr with wrap (NUM_REGS-1 → 0).
- RDATA: shift out regs[ptr], which is latched at the fall after ACK. In RDATA_ACK, the master's ACK increments ptr (wrap) and leads to RDATA. The master's NACK leads to IGNORE.
- A STOP mid-byte discards the partial byte; regs are unchanged.
- The pointer persists across transactions, so a read following a write-pointer-only transaction starts at that pointer.

## Timing
- Reset values: regs all 0, wr_strobe 0, wr_index 0, busy 0, SDA high-Z, state IDLE, ptr 0.
- Detection latency for SCL/SDA events is 3 clk after the pin change.
- wr_strobe asserts 1 clk after the 8th data-bit SCL rise is detected. regs updates on the same edge.
- ACK drive starts at the detected SCL fall after bit 8 and is released at the detected SCL fall after bit 9.
- busy rises the clk after START is detected and falls the clk after STOP is detected.
- Reset asserted mid-transfer releases SDA immediately and asynchronously.

## Configuration
- I2C_SLV_READ_EN defined: the RDATA/RDATA_ACK path is present, and an address match with R/W=1 is ACKed.
- I2C_SLV_READ_EN undefined: the read states are compiled out, and an address match with R/W=1 is NACKed → IGNORE. The write path is identical.

## Structure
- Package i2c_slv_pkg holds the state enum, the I2C_RW_READ/I2C_RW_WRITE constants, and the ACK/NACK constants.
- Sub-module i2c_bus_sync holds the synchronisers plus the scl_rise, scl_fall, start_det and stop_det pulses; it is reused by the master.

## Test plan
- Write to 0x42 with ptr 0x01, data 0xA5 → ACK on all 3 bytes; regs[15:8]=0xA5; one wr_strobe with wr_index=1.
- Burst write with ptr 0x02, data 0x11 0x22 0x33 (NUM_REGS=4) → reg2=0x11, reg3=0x22, reg0=0x33 via wrap; 3 strobes.
- Address 0x43 → NACK; SDA never driven; regs unchanged; busy still pulses START-to-STOP.
- Pointer 0x07 with NUM_REGS=4 → pointer NACK; following data ignored; no strobe.
- With READ_EN: write ptr 0x03, repeated START, read 2 bytes (ACK, then NACK) → bytes returned are reg3 and reg0. Without READ_EN → read address NACKed.
- STOP after 5 data bits, then reset asserted during a later ACK → regs unchanged by the partial byte; SDA high-Z within 1 clk of reset.
